// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM: fetch/decode/execute/memory/writeback sequencing with
// bounded memory wait, sticky FAULT and illegal detection. Optional macro: CTRL_RETIRE_CNT_EN.
module multicycle_control_unit #(
  parameter int INSTR_WIDTH    = 32,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int WAIT_CNT_WIDTH = 4,
  parameter int MAX_WAIT       = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [INSTR_WIDTH-1:0]    instr_i,
  input  logic                      zero_i,
  input  logic                      lt_i,
  input  logic                      mem_ready_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic                      adr_src_o,
  output logic                      ir_write_o,
  output logic                      pc_write_o,
  output logic                      reg_write_o,
  output logic [1:0]                result_src_o,
  output logic [1:0]                alu_src_a_o,
  output logic [1:0]                alu_src_b_o,
  output logic [1:0]                imm_src_o,
  output logic [ALU_CTRL_WIDTH-1:0] alu_control_o,
  output logic                      illegal_o,
  output logic                      fault_o,
  output logic [31:0]               retire_cnt_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_FAULT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b010);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b011);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR = ALU_CTRL_WIDTH'(3'b100);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b101);

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_WAIT_C = WAIT_CNT_WIDTH'(MAX_WAIT);

  state_t                      state, state_next;
  logic [WAIT_CNT_WIDTH-1:0]   wait_cnt;
  logic                        mem_wait, timeout;
  logic [6:0]                  opcode;
  logic [2:0]                  funct3;
  logic                        funct7_5;

  logic                        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal;
  logic [1:0]                  result_src, alu_src_a, alu_src_b, imm_src;
  logic [ALU_CTRL_WIDTH-1:0]   alu_control;
  logic                        unused_instr_bits;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign funct7_5 = instr_i[30];
  assign unused_instr_bits = ^{instr_i[INSTR_WIDTH-1:31], instr_i[29:15], instr_i[11:7]};

  assign mem_wait = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !mem_ready_i;
  assign timeout  = mem_wait && (wait_cnt == MAX_WAIT_C);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (mem_ready_i || state_next != state)
        wait_cnt <= '0;
      else if (mem_wait)
        wait_cnt <= wait_cnt + WAIT_CNT_WIDTH'(1);
    end
  end

  // A wait that hits the limit drops every strobe, including the request itself.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    imm_src     = 2'b00;
    alu_control = ALU_ADD;
    state_next  = state;
    case (state)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        mem_req    = !timeout;
        if (mem_ready_i) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end else if (timeout) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (opcode == OP_JAL) ? 2'b11 : 2'b10;
        case (opcode)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          default: begin
            illegal    = 1'b1;
            state_next = S_FAULT;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b01;
        imm_src    = (opcode == OP_STORE) ? 2'b01 : 2'b00;
        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = !timeout;
        adr_src = !timeout;
        if (mem_ready_i)  state_next = S_MEMWB;
        else if (timeout) state_next = S_FAULT;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = !timeout;
        mem_we  = !timeout;
        adr_src = !timeout;
        if (mem_ready_i)  state_next = S_FETCH;
        else if (timeout) state_next = S_FAULT;
      end
      S_EXECR, S_EXECI: begin
        alu_src_a  = 2'b10;
        alu_src_b  = (state == S_EXECI) ? 2'b01 : 2'b00;
        state_next = S_ALUWB;
        case (funct3)
          3'b000:  alu_control = (state == S_EXECR && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: begin
            illegal    = 1'b1;
            state_next = S_FAULT;
          end
        endcase
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        state_next  = S_FETCH;
        case (funct3)
          3'b000:  pc_write = zero_i;
          3'b001:  pc_write = !zero_i;
          3'b100:  pc_write = lt_i;
          3'b101:  pc_write = !lt_i;
          default: begin
            illegal    = 1'b1;
            state_next = S_FAULT;
          end
        endcase
      end
      // PC takes the target precomputed in DECODE; ALU forms oldPC+4 for rd.
      S_JAL: begin
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        imm_src    = 2'b11;
        pc_write   = 1'b1;
        state_next = S_ALUWB;
      end
      S_FAULT:  state_next = S_FAULT;
      default:  state_next = S_FAULT;
    endcase
  end

  assign mem_req_o     = rst_ni & mem_req;
  assign mem_we_o      = rst_ni & mem_we;
  assign adr_src_o     = rst_ni & adr_src;
  assign ir_write_o    = rst_ni & ir_write;
  assign pc_write_o    = rst_ni & pc_write;
  assign reg_write_o   = rst_ni & reg_write;
  assign illegal_o     = rst_ni & illegal;
  assign fault_o       = rst_ni & (state == S_FAULT);
  assign result_src_o  = rst_ni ? result_src : 2'b00;
  assign alu_src_a_o   = rst_ni ? alu_src_a : 2'b00;
  assign alu_src_b_o   = rst_ni ? alu_src_b : 2'b00;
  assign imm_src_o     = rst_ni ? imm_src : 2'b00;
  assign alu_control_o = rst_ni ? alu_control : '0;

`ifdef CTRL_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      retire_cnt <= '0;
    else if (state_next == S_FETCH &&
             (state == S_MEMWB || state == S_MEMWRITE || state == S_ALUWB || state == S_BRANCH))
      retire_cnt <= retire_cnt + 32'd1;
  end

  assign retire_cnt_o = retire_cnt;
`else
  assign retire_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a per-cycle vector table through every
// instruction class, then hand sequences for illegal, wait timeout, reset and retire count.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'd0;
  logic        zero = 1'b0, lt = 1'b0, ready = 1'b0;
  logic        mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, illegal, fault;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] retire_cnt;
  logic [18:0] obs;

  int checks = 0;
  int errors = 0;

  multicycle_control_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_i(instr), .zero_i(zero), .lt_i(lt),
    .mem_ready_i(ready), .mem_req_o(mem_req), .mem_we_o(mem_we), .adr_src_o(adr_src),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .reg_write_o(reg_write),
    .result_src_o(result_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .imm_src_o(imm_src), .alu_control_o(alu_control), .illegal_o(illegal),
    .fault_o(fault), .retire_cnt_o(retire_cnt)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal, fault};

  localparam logic [31:0] ADDI  = 32'h00500093;
  localparam logic [31:0] LW    = 32'h0000A103;
  localparam logic [31:0] SW    = 32'h0020A223;
  localparam logic [31:0] SUB   = 32'h402081B3;
  localparam logic [31:0] XOR_R = 32'h0020C1B3;
  localparam logic [31:0] SLL_R = 32'h002091B3;
  localparam logic [31:0] BEQ   = 32'h00208463;
  localparam logic [31:0] BNE   = 32'h00209463;
  localparam logic [31:0] BLT   = 32'h0020C463;
  localparam logic [31:0] BGE   = 32'h0020D463;
  localparam logic [31:0] JAL   = 32'h010000EF;
  localparam logic [31:0] BAD   = 32'hFFFFFFFF;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    logic        ready;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [18:0] ov(logic req, logic we, logic adr, logic irw, logic pcw,
                                     logic rw, logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] imm, logic [2:0] alu, logic ill, logic flt);
    return {req, we, adr, irw, pcw, rw, rs, a, b, imm, alu, ill, flt};
  endfunction

  function automatic vec_t mk(string n, logic [31:0] i, logic z, logic l, logic r, logic [18:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.zero = z; v.lt = l; v.ready = r; v.exp = e;
    return v;
  endfunction

  logic [18:0] e_fetch, e_fetch_nr, e_dec, e_dec_jal, e_dec_ill, e_execi, e_aluwb;
  logic [18:0] e_madr_lw, e_madr_sw, e_memread, e_memwb, e_memwrite, e_jal, e_fault;
  logic [18:0] e_execr_ill;

  task automatic applyStimulus(input logic [31:0] i, input logic z, input logic l, input logic r);
    instr = i; zero = z; lt = l; ready = r;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [18:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, obs, exp);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runVector(input vec_t v);
    applyStimulus(v.instr, v.zero, v.lt, v.ready);
    checkOutput(v.name, v.exp);
    @(negedge clk);
  endtask

  task automatic driveCycle(input logic [31:0] i, input logic z, input logic r);
    applyStimulus(i, z, 1'b0, r);
    @(negedge clk);
  endtask

  // Reset is pulsed mid-cycle; outputs must read all-zero while it is held low.
  task automatic doReset(input string name);
    #2 rst_n = 1'b0;
    ready = 1'b1;
    #1;
    checkOutput({name, ".in_reset"}, 19'd0);
    checkValue({name, ".retire_in_reset"}, retire_cnt, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    e_fetch     = ov(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0);
    e_fetch_nr  = ov(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0);
    e_dec       = ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0);
    e_dec_jal   = ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0);
    e_dec_ill   = ov(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,1,0);
    e_execi     = ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0);
    e_aluwb     = ov(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0,0);
    e_madr_lw   = ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0);
    e_madr_sw   = ov(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0);
    e_memread   = ov(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0);
    e_memwb     = ov(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0,0);
    e_memwrite  = ov(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0);
    e_jal       = ov(0,0,0,0,1,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0);
    e_fault     = ov(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,1);
    e_execr_ill = ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,1,0);

    vecs.push_back(mk("addi.fetch",  ADDI, 0, 0, 1, e_fetch));
    vecs.push_back(mk("addi.decode", ADDI, 0, 0, 1, e_dec));
    vecs.push_back(mk("addi.execi",  ADDI, 0, 0, 1, e_execi));
    vecs.push_back(mk("addi.aluwb",  ADDI, 0, 0, 1, e_aluwb));
    vecs.push_back(mk("lw.fetch",    LW, 0, 0, 1, e_fetch));
    vecs.push_back(mk("lw.decode",   LW, 0, 0, 1, e_dec));
    vecs.push_back(mk("lw.memadr",   LW, 0, 0, 1, e_madr_lw));
    vecs.push_back(mk("lw.memrd_w1", LW, 0, 0, 0, e_memread));
    vecs.push_back(mk("lw.memrd_w2", LW, 0, 0, 0, e_memread));
    vecs.push_back(mk("lw.memrd_w3", LW, 0, 0, 0, e_memread));
    vecs.push_back(mk("lw.memrd_ok", LW, 0, 0, 1, e_memread));
    vecs.push_back(mk("lw.memwb",    LW, 0, 0, 1, e_memwb));
    vecs.push_back(mk("bne0.fetch",  BNE, 0, 0, 1, e_fetch));
    vecs.push_back(mk("bne0.decode", BNE, 0, 0, 1, e_dec));
    vecs.push_back(mk("bne0.branch", BNE, 0, 0, 1, ov(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0)));
    vecs.push_back(mk("bne1.fetch",  BNE, 1, 0, 1, e_fetch));
    vecs.push_back(mk("bne1.decode", BNE, 1, 0, 1, e_dec));
    vecs.push_back(mk("bne1.branch", BNE, 1, 0, 1, ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0)));
    vecs.push_back(mk("sub.fetch",   SUB, 0, 0, 1, e_fetch));
    vecs.push_back(mk("sub.decode",  SUB, 0, 0, 1, e_dec));
    vecs.push_back(mk("sub.execr",   SUB, 0, 0, 1, ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0)));
    vecs.push_back(mk("sub.aluwb",   SUB, 0, 0, 1, e_aluwb));
    vecs.push_back(mk("xor.fetch",   XOR_R, 0, 0, 1, e_fetch));
    vecs.push_back(mk("xor.decode",  XOR_R, 0, 0, 1, e_dec));
    vecs.push_back(mk("xor.execr",   XOR_R, 0, 0, 1, ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b100,0,0)));
    vecs.push_back(mk("xor.aluwb",   XOR_R, 0, 0, 1, e_aluwb));
    vecs.push_back(mk("sw.fetch",    SW, 0, 0, 1, e_fetch));
    vecs.push_back(mk("sw.decode",   SW, 0, 0, 1, e_dec));
    vecs.push_back(mk("sw.memadr",   SW, 0, 0, 1, e_madr_sw));
    vecs.push_back(mk("sw.memwrite", SW, 0, 0, 1, e_memwrite));
    vecs.push_back(mk("blt.fetch",   BLT, 0, 1, 1, e_fetch));
    vecs.push_back(mk("blt.decode",  BLT, 0, 1, 1, e_dec));
    vecs.push_back(mk("blt.branch",  BLT, 0, 1, 1, ov(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0)));
    vecs.push_back(mk("bge.fetch",   BGE, 0, 1, 1, e_fetch));
    vecs.push_back(mk("bge.decode",  BGE, 0, 1, 1, e_dec));
    vecs.push_back(mk("bge.branch",  BGE, 0, 1, 1, ov(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0)));
    vecs.push_back(mk("jal.fetch",   JAL, 0, 0, 1, e_fetch));
    vecs.push_back(mk("jal.decode",  JAL, 0, 0, 1, e_dec_jal));
    vecs.push_back(mk("jal.jal",     JAL, 0, 0, 1, e_jal));
    vecs.push_back(mk("jal.aluwb",   JAL, 0, 0, 1, e_aluwb));

    @(negedge clk);
    doReset("init");
    foreach (vecs[k]) runVector(vecs[k]);
`ifdef CTRL_RETIRE_CNT_EN
    checkValue("table.retire", retire_cnt, 32'd10);
`else
    checkValue("table.retire", retire_cnt, 32'd0);
`endif

    // Undecodable word: one illegal pulse, then FAULT holds regardless of inputs.
    doReset("ill");
    runVector(mk("ill.fetch",  BAD, 0, 0, 1, e_fetch));
    runVector(mk("ill.decode", BAD, 0, 0, 1, e_dec_ill));
    for (int c = 0; c < 11; c++) runVector(mk($sformatf("ill.fault%0d", c), BAD, c[0], 0, 1, e_fault));

    doReset("execr_ill");
    runVector(mk("sll.fetch",  SLL_R, 0, 0, 1, e_fetch));
    runVector(mk("sll.decode", SLL_R, 0, 0, 1, e_dec));
    runVector(mk("sll.execr",  SLL_R, 0, 0, 1, e_execr_ill));
    runVector(mk("sll.fault",  SLL_R, 0, 0, 1, e_fault));

    // Ready arriving on the cycle the wait counter sits at its limit still completes.
    doReset("rdywin");
    for (int c = 0; c < 15; c++) runVector(mk($sformatf("rdywin.nr%0d", c), ADDI, 0, 0, 0, e_fetch_nr));
    runVector(mk("rdywin.fetch",  ADDI, 0, 0, 1, e_fetch));
    runVector(mk("rdywin.decode", ADDI, 0, 0, 1, e_dec));
    runVector(mk("rdywin.execi",  ADDI, 0, 0, 1, e_execi));

    doReset("tmo");
    for (int c = 0; c < 16; c++) begin
      applyStimulus(ADDI, 1'b0, 1'b0, 1'b0);
      checkValue($sformatf("tmo.nofault%0d", c), {31'd0, fault}, 32'd0);
      @(negedge clk);
    end
    runVector(mk("tmo.fault", ADDI, 0, 0, 0, e_fault));
    runVector(mk("tmo.fault_hold", ADDI, 0, 0, 1, e_fault));
    doReset("tmo_mid");
    runVector(mk("tmo.refetch", ADDI, 0, 0, 1, e_fetch));
    runVector(mk("tmo.redecode", ADDI, 0, 0, 1, e_dec));

    doReset("retire");
    for (int n = 0; n < 3; n++) for (int c = 0; c < 4; c++) driveCycle(ADDI, 1'b0, 1'b1);
    for (int c = 0; c < 4; c++) driveCycle(SW, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) driveCycle(BEQ, 1'b1, 1'b1);
`ifdef CTRL_RETIRE_CNT_EN
    checkValue("retire.five", retire_cnt, 32'd5);
`else
    checkValue("retire.five", retire_cnt, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Next-generation RV32I control unit for the multicycle datapath: one shared instruction/data memory, IR, and ALU reused across cycles.
- Moore FSM plus a decode stage, sequencing fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq/bne/blt/bge and jal.
- Adds a memory ready handshake with a bounded wait counter, a sticky fault state, and illegal-instruction detection.
- Sits between the IR/ALU flags and all datapath mux/enable strobes.

Parameters:
- INSTR_WIDTH, 32, instruction width; opcode [6:0], funct3 [14:12], funct7 [31:25].
- ALU_CTRL_WIDTH, 3, width of alu_control_o.
- WAIT_CNT_WIDTH, 4, width of the memory wait counter.
- MAX_WAIT, 15, number of consecutive not-ready cycles tolerated before fault. Must be at most 2^WAIT_CNT_WIDTH-1.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- instr_i  in  INSTR_WIDTH  IR contents, valid from DECODE onward.
- zero_i  in  1  ALU result == 0.
- lt_i  in  1  ALU signed less-than.
- mem_ready_i  in  1  memory completes the current access this cycle.
- mem_req_o  out  1  memory access request.
- mem_we_o  out  1  memory write enable.
- adr_src_o  out  1  0 = PC, 1 = ALUOut.
- ir_write_o  out  1  IR/oldPC load.
- pc_write_o  out  1  PC load.
- reg_write_o  out  1  register file write.
- result_src_o  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- alu_src_a_o  out  2  00 PC, 01 oldPC, 10 rs1.
- alu_src_b_o  out  2  00 rs2, 01 imm, 10 const 4.
- imm_src_o  out  2  00 I, 01 S, 10 B, 11 J.
- alu_control_o  out  ALU_CTRL_WIDTH  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- illegal_o  out  1  one-cycle pulse on an undecodable instruction.
- fault_o  out  1  FSM is in FAULT.
- retire_cnt_o  out  32  retired-instruction count (see Optional Feature).

Behaviour:
- State register updates on the clk_i rising edge. rst_ni low asynchronously forces FETCH and clears the wait counter.
- While rst_ni is low, all outputs are 0, including mem_req_o.
- Outputs are combinational from state, instr_i and the flags. Strobes default to 0; mux selects default to 00.
- FETCH: mem_req_o=1, adr_src_o=0, alu_src_a_o=00, alu_src_b_o=10, add, result_src_o=10.
  - If mem_ready_i: ir_write_o=1, pc_write_o=1, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle): alu_src_a_o=01, alu_src_b_o=01, imm_src_o=10, add; this precomputes the branch target into ALUOut. Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - anything else -> illegal_o=1, next FAULT
- MEMADR: alu_src_a_o=10, alu_src_b_o=01, add; imm_src_o=00 for lw, 01 for sw. Next MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req_o=1, adr_src_o=1. If mem_ready_i, next MEMWB; otherwise stay.
- MEMWB: result_src_o=01, reg_write_o=1, next FETCH.
- MEMWRITE: mem_req_o=1, mem_we_o=1, adr_src_o=1. If mem_ready_i, next FETCH; otherwise stay.
- EXECR: alu_src_a_o=10, alu_src_b_o=00, ALU op from funct3:
  - 000: add, or sub when funct7[5]=1
  - 010: slt
  - 100: xor
  - 110: or
  - 111: and
  - other funct3 -> illegal_o=1, next FAULT
  - Otherwise next ALUWB.
- EXECI: same decode with alu_src_b_o=01 and imm_src_o=00; funct7 ignored, always add for funct3 000. Next ALUWB.
- ALUWB: result_src_o=00, reg_write_o=1, next FETCH.
- BRANCH: alu_src_a_o=10, alu_src_b_o=00, sub, result_src_o=00. pc_write_o by funct3:
  - 000 (beq): zero_i
  - 001 (bne): !zero_i
  - 100 (blt): lt_i
  - 101 (bge): !lt_i
  - other funct3 -> illegal_o=1, next FAULT
  - Otherwise next FETCH.
- JAL: alu_src_a_o=01, alu_src_b_o=10, add, result_src_o=00, pc_write_o=1, imm_src_o=11, next ALUWB.
  - PC is loaded from ALUOut, which holds oldPC+immJ computed in DECODE with imm_src_o=11 for jal.
  - rd receives oldPC+4.
- Wait counter:
  - Increments on each cycle in FETCH, MEMREAD or MEMWRITE with mem_req_o=1 and mem_ready_i=0.
  - Clears on any cycle with mem_ready_i=1 and on any state change.
  - Not ready with counter == MAX_WAIT -> next FAULT, no strobes.
  - mem_ready_i on the same cycle as the limit is reached: ready wins.
- FAULT: sticky until reset. All strobes 0, fault_o=1.

Optional Feature:
- Macro: CTRL_RETIRE_CNT_EN.
- Defined: 32-bit retire counter, reset to 0. Increments on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH, wrapping 0xFFFFFFFF -> 0. Drives retire_cnt_o.
- Undefined: no counter register; retire_cnt_o tied to 0.

Test Plan:
- addi x1,x0,5 (0x00500093) with ready every cycle -> FETCH, DECODE, EXECI, ALUWB, FETCH; reg_write_o=1 in ALUWB with result_src_o=00; 4 cycles per instruction.
- lw with mem_ready_i low for 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB with result_src_o=01 and reg_write_o=1; no fault.
- bne with zero_i=0, then with zero_i=1 -> pc_write_o=1 in BRANCH for the first, 0 for the second; both return to FETCH.
- instr_i=0xFFFFFFFF -> illegal_o pulses once in DECODE, fault_o=1 from the next cycle and stays set through 10 further cycles.
- mem_ready_i held 0 in FETCH -> FAULT entered after MAX_WAIT+1=16 not-ready cycles; rst_ni pulse mid-FAULT returns to FETCH with outputs 0 while low.
- CTRL_RETIRE_CNT_EN defined: run 3 addi, 1 sw, 1 taken beq -> retire_cnt_o=5; undefined -> retire_cnt_o=0.
